// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes and the EX->MS payload layout for the memory stage.
// Optional misaligned-load detection is enabled by defining MS_ADEL_CHECK_EN.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 77;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FW_WD        = 38;

    // Codes 5..7 are not listed and fall back to a plain word load.
    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
        logic        dest_valid;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/ms_load_align.sv
// Combinational sub-word load alignment: picks the addressed byte/halfword out of
// the read word and sign- or zero-extends it according to the load type.
module ms_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_ld_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword selection deliberately ignores addr_lo[0].
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = i_rdata;
        case (i_ld_type)
            LD_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_load_data = {24'd0, w_byte};
            LD_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: registers the EX payload, captures SRAM read data across WS stalls,
// aligns loads and drives the WS and forwarding buses. Optional macro: MS_ADEL_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FW_WD-1:0]        ms_to_ds_fw,
    output logic                       ms_adel
);

    logic        r_ms_valid;
    logic        r_ms_first;
    logic        r_rdata_buf_valid;
    logic [31:0] r_rdata_buf;
    es_to_ms_t   r_es_bus;

    logic        w_ms_ready_go;
    logic        w_accept;
    logic        w_leave;
    logic        w_capture;
    logic [31:0] w_rdata_sel;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic        w_adel;
    logic        w_gr_we;
    logic        w_fw_valid;

    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_accept       = es_to_ms_valid && ms_allowin;
    assign w_leave        = r_ms_valid && ws_allowin;
    // SRAM data is only valid in the first MS cycle, so grab it if WS stalls us there.
    assign w_capture      = r_ms_valid && r_ms_first && !ws_allowin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ms_valid        <= 1'b0;
            r_ms_first        <= 1'b0;
            r_rdata_buf_valid <= 1'b0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            r_ms_first <= w_accept;
            if (w_leave || w_accept) begin
                r_rdata_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_rdata_buf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_es_bus <= es_to_ms_bus;
        end
        if (w_capture) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    assign w_rdata_sel = r_rdata_buf_valid ? r_rdata_buf : data_sram_rdata;

    ms_load_align u_load_align (
        .i_ld_type   (r_es_bus.ld_type),
        .i_addr_lo   (r_es_bus.addr_lo),
        .i_rdata     (w_rdata_sel),
        .o_load_data (w_load_data)
    );

    assign w_final_result = r_es_bus.res_from_mem ? w_load_data : r_es_bus.result;

`ifdef MS_ADEL_CHECK_EN
    // Only exact LW is word-alignment checked; codes 5..7 pass through unflagged.
    assign w_adel = r_ms_valid && r_es_bus.res_from_mem &&
                    ((((r_es_bus.ld_type == LD_LH) || (r_es_bus.ld_type == LD_LHU)) && r_es_bus.addr_lo[0]) ||
                     ((r_es_bus.ld_type == LD_LW) && (r_es_bus.addr_lo != 2'd0)));
`else
    assign w_adel = 1'b0;
`endif

    assign ms_adel     = w_adel;
    assign w_gr_we     = r_es_bus.gr_we && !w_adel;
    assign w_fw_valid  = r_ms_valid && r_es_bus.dest_valid && !w_adel;

    assign ms_to_ws_bus = {w_gr_we, r_es_bus.dest, w_final_result, r_es_bus.pc};
    assign ms_to_ds_fw  = {w_fw_valid, r_es_bus.dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single loads/ALU ops plus hand-written
// sequences for stalls, back-to-back flow and asynchronous reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef logic [69:0] chk_t;

    typedef struct {
        string       name;
        logic [2:0]  ldType;
        logic [1:0]  addrLo;
        logic        destValid;
        logic        resFromMem;
        logic        grWe;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] expFinal;
        logic        expGrWe;
        logic        expFw;
        logic        expAdel;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [76:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_to_ds_fw;
    logic        ms_adel;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ds_fw     (ms_to_ds_fw),
        .ms_adel         (ms_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [76:0] makeBus(input logic [2:0] ldType, input logic [1:0] addrLo,
                                            input logic destValid, input logic resFromMem,
                                            input logic grWe, input logic [4:0] dest,
                                            input logic [31:0] result, input logic [31:0] pc);
        return {ldType, addrLo, destValid, resFromMem, grWe, dest, result, pc};
    endfunction

    // Misaligned vectors only change their expectations when the checker is built in.
    task automatic addVec(input string name, input logic [2:0] ldType, input logic [1:0] addrLo,
                          input logic destValid, input logic resFromMem, input logic grWe,
                          input logic [4:0] dest, input logic [31:0] result, input logic [31:0] pc,
                          input logic [31:0] rdata, input logic [31:0] expFinal, input logic misaligned);
        vec_t v;
        v.name = name; v.ldType = ldType; v.addrLo = addrLo; v.destValid = destValid;
        v.resFromMem = resFromMem; v.grWe = grWe; v.dest = dest; v.result = result; v.pc = pc;
        v.rdata = rdata; v.expFinal = expFinal;
        v.expGrWe = grWe; v.expFw = destValid; v.expAdel = 1'b0;
`ifdef MS_ADEL_CHECK_EN
        if (misaligned) begin
            v.expGrWe = 1'b0; v.expFw = 1'b0; v.expAdel = 1'b1;
        end
`else
        if (misaligned) v.expAdel = 1'b0;
`endif
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic esValid, input logic [76:0] bus,
                                 input logic wsAllow, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        es_to_ms_valid  = esValid;
        es_to_ms_bus    = bus;
        ws_allowin      = wsAllow;
        data_sram_rdata = rdata;
    endtask

    task automatic checkOutput(input string name, input chk_t actual, input chk_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    initial begin
        reset           = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;

        addVec("lw",       LD_LW,  2'd0, 1, 1, 1, 5'd3,  32'h1111,     32'hBFC00000, 32'h89ABCDEF, 32'h89ABCDEF, 0);
        addVec("lb3",      LD_LB,  2'd3, 1, 1, 1, 5'd4,  32'h0,        32'hBFC00004, 32'h80FF0102, 32'hFFFFFF80, 0);
        addVec("lbu3",     LD_LBU, 2'd3, 1, 1, 1, 5'd5,  32'h0,        32'hBFC00008, 32'h80FF0102, 32'h00000080, 0);
        addVec("lh2",      LD_LH,  2'd2, 1, 1, 1, 5'd6,  32'h0,        32'hBFC0000C, 32'h80FF0102, 32'hFFFF80FF, 0);
        addVec("lhu2",     LD_LHU, 2'd2, 1, 1, 1, 5'd7,  32'h0,        32'hBFC00010, 32'h80FF0102, 32'h000080FF, 0);
        addVec("lb1",      LD_LB,  2'd1, 1, 1, 1, 5'd8,  32'h0,        32'hBFC00014, 32'h80FF0102, 32'h00000001, 0);
        addVec("lb0",      LD_LB,  2'd0, 1, 1, 1, 5'd9,  32'h0,        32'hBFC00018, 32'h000000F0, 32'hFFFFFFF0, 0);
        addVec("lbu2",     LD_LBU, 2'd2, 1, 1, 1, 5'd10, 32'h0,        32'hBFC0001C, 32'h80FF0102, 32'h000000FF, 0);
        addVec("lh0",      LD_LH,  2'd0, 1, 1, 1, 5'd11, 32'h0,        32'hBFC00020, 32'h12348001, 32'hFFFF8001, 0);
        addVec("ld6",      3'd6,   2'd0, 1, 1, 1, 5'd12, 32'h0,        32'hBFC00024, 32'h12345678, 32'h12345678, 0);
        addVec("alu",      LD_LW,  2'd0, 0, 0, 1, 5'd13, 32'h5,        32'hBFC00028, 32'hDEADBEEF, 32'h00000005, 0);
        addVec("alu_nowe", LD_LW,  2'd0, 1, 0, 0, 5'd14, 32'hCAFEF00D, 32'hBFC0002C, 32'h0,        32'hCAFEF00D, 0);
        addVec("alu_odd",  LD_LW,  2'd3, 1, 0, 1, 5'd15, 32'h42,       32'hBFC00030, 32'hFFFFFFFF, 32'h00000042, 0);
        addVec("lh1",      LD_LH,  2'd1, 1, 1, 1, 5'd16, 32'h0,        32'hBFC00034, 32'h7FFF8001, 32'hFFFF8001, 1);
        addVec("lhu3",     LD_LHU, 2'd3, 1, 1, 1, 5'd17, 32'h0,        32'hBFC00038, 32'h80FF0102, 32'h000080FF, 1);
        addVec("lw2",      LD_LW,  2'd2, 1, 1, 1, 5'd18, 32'h0,        32'hBFC0003C, 32'hA5A55A5A, 32'hA5A55A5A, 1);

        #1;
        checkOutput("rst_ws_valid", chk_t'(ms_to_ws_valid), chk_t'(0));
        checkOutput("rst_fw_valid", chk_t'(ms_to_ds_fw[37]), chk_t'(0));
        checkOutput("rst_adel",     chk_t'(ms_adel),        chk_t'(0));
        checkOutput("rst_allowin",  chk_t'(ms_allowin),     chk_t'(1));
        #11;
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(1'b1, makeBus(vecs[i].ldType, vecs[i].addrLo, vecs[i].destValid,
                                        vecs[i].resFromMem, vecs[i].grWe, vecs[i].dest,
                                        vecs[i].result, vecs[i].pc), 1'b1, 32'h0);
            applyStimulus(1'b0, '0, 1'b1, vecs[i].rdata);
            @(negedge clk);
            checkOutput({vecs[i].name, "_valid"}, chk_t'(ms_to_ws_valid), chk_t'(1));
            checkOutput({vecs[i].name, "_wsbus"}, chk_t'(ms_to_ws_bus),
                        {vecs[i].expGrWe, vecs[i].dest, vecs[i].expFinal, vecs[i].pc});
            checkOutput({vecs[i].name, "_fw"}, chk_t'(ms_to_ds_fw),
                        chk_t'({vecs[i].expFw, vecs[i].dest, vecs[i].expFinal}));
            checkOutput({vecs[i].name, "_adel"}, chk_t'(ms_adel), chk_t'(vecs[i].expAdel));
            applyStimulus(1'b0, '0, 1'b1, 32'h0);
            @(negedge clk);
            checkOutput({vecs[i].name, "_drained"}, chk_t'(ms_to_ws_valid), chk_t'(0));
        end

        // Stall with the SRAM word changing underneath, then leave and accept in one cycle.
        applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 1, 1, 5'd7, 32'h0, 32'h100), 1'b1, 32'h0);
        applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 1, 1, 5'd8, 32'h0, 32'h104), 1'b0, 32'h11223344);
        @(negedge clk);
        checkOutput("stall0_valid",   chk_t'(ms_to_ws_valid),      chk_t'(1));
        checkOutput("stall0_result",  chk_t'(ms_to_ws_bus[63:32]), chk_t'(32'h11223344));
        checkOutput("stall0_allowin", chk_t'(ms_allowin),          chk_t'(0));
        for (int c = 1; c <= 2; c++) begin
            applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 1, 1, 5'd8, 32'h0, 32'h104), 1'b0, 32'hDEADBEEF);
            @(negedge clk);
            checkOutput($sformatf("stall%0d_result", c),  chk_t'(ms_to_ws_bus[63:32]), chk_t'(32'h11223344));
            checkOutput($sformatf("stall%0d_fw", c),      chk_t'(ms_to_ds_fw[31:0]),   chk_t'(32'h11223344));
            checkOutput($sformatf("stall%0d_pc", c),      chk_t'(ms_to_ws_bus[31:0]),  chk_t'(32'h100));
            checkOutput($sformatf("stall%0d_allowin", c), chk_t'(ms_allowin),          chk_t'(0));
        end
        applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 1, 1, 5'd8, 32'h0, 32'h104), 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("release_result",  chk_t'(ms_to_ws_bus[63:32]), chk_t'(32'h11223344));
        checkOutput("release_allowin", chk_t'(ms_allowin),          chk_t'(1));
        applyStimulus(1'b0, '0, 1'b1, 32'h55667788);
        @(negedge clk);
        checkOutput("next_valid",  chk_t'(ms_to_ws_valid),      chk_t'(1));
        checkOutput("next_result", chk_t'(ms_to_ws_bus[63:32]), chk_t'(32'h55667788));
        checkOutput("next_pc",     chk_t'(ms_to_ws_bus[31:0]),  chk_t'(32'h104));
        applyStimulus(1'b0, '0, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("next_drained", chk_t'(ms_to_ws_valid), chk_t'(0));

        // ALU result followed directly by a load: two transfers with no bubble.
        applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 0, 1, 5'd9,  32'h5, 32'h200), 1'b1, 32'h0);
        applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 1, 1, 5'd10, 32'h0, 32'h204), 1'b1, 32'h0000FFFF);
        @(negedge clk);
        checkOutput("b2b_alu_valid",  chk_t'(ms_to_ws_valid),      chk_t'(1));
        checkOutput("b2b_alu_result", chk_t'(ms_to_ws_bus[63:32]), chk_t'(32'h5));
        applyStimulus(1'b0, '0, 1'b1, 32'h7);
        @(negedge clk);
        checkOutput("b2b_lw_valid",  chk_t'(ms_to_ws_valid),      chk_t'(1));
        checkOutput("b2b_lw_result", chk_t'(ms_to_ws_bus[63:32]), chk_t'(32'h7));
        checkOutput("b2b_lw_pc",     chk_t'(ms_to_ws_bus[31:0]),  chk_t'(32'h204));
        applyStimulus(1'b0, '0, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("b2b_drained", chk_t'(ms_to_ws_valid), chk_t'(0));

        // Asynchronous reset in the middle of a stall.
        applyStimulus(1'b1, makeBus(LD_LW, 2'd0, 1, 1, 1, 5'd11, 32'h0, 32'h300), 1'b1, 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 32'hABCD0123);
        @(negedge clk);
        checkOutput("prerst_valid", chk_t'(ms_to_ws_valid), chk_t'(1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid",   chk_t'(ms_to_ws_valid),  chk_t'(0));
        checkOutput("midrst_fw",      chk_t'(ms_to_ds_fw[37]), chk_t'(0));
        checkOutput("midrst_allowin", chk_t'(ms_allowin),      chk_t'(1));
        @(posedge clk);
        #1;
        reset      = 1'b1;
        ws_allowin = 1'b1;
        @(negedge clk);
        checkOutput("postrst_valid0", chk_t'(ms_to_ws_valid), chk_t'(0));
        applyStimulus(1'b0, '0, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("postrst_valid1", chk_t'(ms_to_ws_valid), chk_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
